// File: rtl/fifo_wr_sched.sv
// fifo_wr_sched: write-side scheduler sharing one async-FIFO write port
// between a byte requester (A) and a two-byte word requester (B).
// Round-robin arbitration with packet lock; every push is followed by a
// gap cycle so the registered wfull reflects that push before the next one.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for en, !wfull and a valid request; arbitrates
//   PUSH   | winc=1 for one cycle with the current low byte of word_buf
//   GAP    | one dead cycle so wfull catches up with the preceding push
//   HOLD   | B's high byte pending; waits for wfull=0 before pushing it

module fifo_wr_sched #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic                      en,
  input  logic                      a_valid,
  input  logic [DATA_WIDTH-1:0]     a_data,
  output logic                      a_ready,
  input  logic                      b_valid,
  input  logic [2*DATA_WIDTH-1:0]   b_data,
  output logic                      b_ready,
  input  logic                      wfull,
  output logic                      winc,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_GAP  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_nxt;

  // Packet buffer: the byte to push next always sits in the low half.
  logic [2*DATA_WIDTH-1:0]   word_buf;
  logic                      remaining;
  // 1 = B was granted last, so A wins the next contention.
  logic                      rr_last_b;
  logic                      owner_b;
  logic                      first_push;

  logic                      grant_any;
  logic                      grant_a;

  assign grant_any = en & ~wfull & (a_valid | b_valid);
  assign grant_a   = a_valid & (~b_valid | rr_last_b);

  // State register.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_any) state_nxt = S_PUSH;
      end
      S_PUSH: begin
        state_nxt = S_GAP;
      end
      S_GAP: begin
        state_nxt = remaining ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!wfull) state_nxt = S_PUSH;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Packet buffer, byte count, ownership and round-robin pointer.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      word_buf   <= '0;
      remaining  <= 1'b0;
      rr_last_b  <= 1'b1;
      owner_b    <= 1'b0;
      first_push <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            word_buf   <= grant_a ? {{DATA_WIDTH{1'b0}}, a_data} : b_data;
            remaining  <= ~grant_a;
            rr_last_b  <= ~grant_a;
            owner_b    <= ~grant_a;
            first_push <= 1'b1;
          end
        end
        S_PUSH: begin
          first_push <= 1'b0;
        end
        S_HOLD: begin
          if (!wfull) begin
            remaining <= 1'b0;
            word_buf  <= {{DATA_WIDTH{1'b0}}, word_buf[2*DATA_WIDTH-1:DATA_WIDTH]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from registered state only; no input-to-output path.
  always_comb begin
    winc    = (state == S_PUSH);
    wdata   = winc ? word_buf[DATA_WIDTH-1:0] : '0;
    a_ready = winc & first_push & ~owner_b;
    b_ready = winc & first_push & owner_b;
    busy    = (state != S_IDLE);
  end

endmodule

// File: doc/fifo_wr_sched.md
Name: fifo_wr_sched

Overview:
Write-side scheduler for the async FIFO write port (winc/wdata/wfull) in the write clock domain. It shares that port between two requesters:
- Requester A: single-byte source (register-file read data).
- Requester B: two-byte source (16-bit ALU result).

It uses round-robin arbitration with packet lock. Writes are paced so that the registered wfull flag is always current before any push.

Parameters:
DATA_WIDTH, 8, FIFO byte width; requester B word is 2*DATA_WIDTH.

Ports:
wclk  in  1  write-domain clock.
wrst  in  1  synchronous reset, active-high.
en  in  1  scheduler enable; sampled only in IDLE.
a_valid  in  1  requester A has a byte.
a_data  in  DATA_WIDTH  requester A byte; held stable while a_valid=1 until accepted.
a_ready  out  1  one-cycle accept pulse to A.
b_valid  in  1  requester B has a word.
b_data  in  2*DATA_WIDTH  requester B word; held stable while b_valid=1 until accepted.
b_ready  out  1  one-cycle accept pulse to B.
wfull  in  1  FIFO full flag (registered, write domain).
winc  out  1  FIFO write strobe.
wdata  out  DATA_WIDTH  FIFO write data; valid when winc=1.
busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset and clock:
  - Synchronous active-high reset on wrst at posedge wclk, one clock domain only.
  - Reset values: all outputs 0, state=IDLE, byte buffer 0, remaining-byte count 0, rr_last=B (so A wins first contention).
- States: IDLE, PUSH, GAP, HOLD.
- IDLE:
  - Grant when en=1, wfull=0 and (a_valid | b_valid).
  - If both are valid, grant the requester that is not rr_last; otherwise grant whichever is valid.
  - On grant: latch the requester data into the buffer, set remaining = 0 for A or 1 for B, update rr_last, go to PUSH.
  - No grant: stay in IDLE.
- PUSH (exactly 1 cycle):
  - winc=1; wdata = current byte. B sends its low byte first, then its high byte.
  - Next state: GAP.
- GAP (exactly 1 cycle):
  - winc=0; this cycle lets FIFO_WR register wfull for the preceding push.
  - remaining=1: go to HOLD. remaining=0: go to IDLE.
- HOLD:
  - wfull=0: decrement remaining, select the high byte, go to PUSH.
  - wfull=1: stay in HOLD with winc=0 indefinitely.
- Handshake:
  - a_ready/b_ready are asserted only during the first PUSH of the granted packet, for exactly one cycle.
  - The requester must drop or replace valid at the end of that cycle.
  - Earliest re-arbitration is 2 cycles after the ready pulse, so a stale valid is never re-granted.
- Output registration: winc, wdata, a_ready, b_ready and busy are all registered or state-decoded (no combinational path from inputs). winc is never high in two consecutive cycles.
- Packet lock: a granted packet always completes before the next grant; B's two bytes are never interleaved with A.
- Latency:
  - A byte: valid seen in IDLE at cycle t → winc at t+1 → IDLE at t+3.
  - B word: winc at t+1 (low byte) and t+4 (high byte, if wfull=0), then IDLE at t+6.
- en=0:
  - Blocks new grants only.
  - An in-flight packet completes even if en drops mid-packet.
- Full handling:
  - wfull=1 in IDLE blocks grants.
  - wfull=1 in HOLD stalls the high byte.
  - winc is never issued while wfull=1 in the preceding state.
- Reset mid-packet: state goes to IDLE, the unsent byte is discarded, winc=0 from the next cycle, and rr_last returns to B.

Test Plan:
1. Reset: wrst high 2 cycles → every output 0 and busy=0. Then a_valid=1 with a_data=0x5A, wfull=0 → a_ready and winc high in the same single cycle with wdata=0x5A, followed by one winc=0 cycle.
2. b_valid=1 with b_data=0xBEEF → winc pulses carry 0xEF then 0xBE, 3 cycles apart; b_ready pulses once, together with the 0xEF push.
3. a_valid and b_valid held continuously (A=0x11, B=0x3322) → wdata sequence 0x11, 0x22, 0x33, 0x11, 0x22, 0x33; A is granted first after reset.
4. wfull forced to 1 during HOLD after B's low byte 0xCD of 0xABCD → winc stays 0 for 5 cycles; wfull released → 0xAB pushed on the next cycle; wfull=1 in IDLE → no grant.
5. en=0 with a_valid=1 for 10 cycles → no a_ready, no winc. Separately, en dropped the cycle after B's grant → both bytes still written, then no further grants.
6. wrst pulsed during HOLD of B=0x7788 → 0x77 is never written. A and B then both valid → A is granted first.
